// File: rtl/apb_cmd_master.sv
// Command/response front end driving a single APB transfer at a time,
// with an optional bound on ACCESS-phase wait states. All outputs are registered.
module apb_cmd_master #(
   parameter int unsigned APB_AW         = 32,
   parameter int unsigned APB_DW         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                pclk,
   input  logic                prst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [APB_AW-1:0]   cmd_addr,
   input  logic                cmd_write,
   input  logic [APB_DW-1:0]   cmd_wdata,
   input  logic [APB_DW/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [APB_DW-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic [APB_AW-1:0]   m_apb_paddr,
   output logic                m_apb_psel,
   output logic                m_apb_penable,
   output logic                m_apb_pwrite,
   output logic [APB_DW-1:0]   m_apb_pwdata,
   output logic [APB_DW/8-1:0] m_apb_pstrb,
   input  logic                m_apb_pready,
   input  logic [APB_DW-1:0]   m_apb_prdata,
   input  logic                m_apb_pslverr
);

   localparam int unsigned SW = APB_DW / 8;
   localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
   logic              ready_d;
   logic [APB_AW-1:0] paddr_d;
   logic              psel_d, penable_d, pwrite_d;
   logic [APB_DW-1:0] pwdata_d;
   logic [SW-1:0]     pstrb_d;
   logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic [APB_DW-1:0] rsp_rdata_d;

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cmd_ready     <= 1'b0;
         m_apb_paddr   <= '0;
         m_apb_psel    <= 1'b0;
         m_apb_penable <= 1'b0;
         m_apb_pwrite  <= 1'b0;
         m_apb_pwdata  <= '0;
         m_apb_pstrb   <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         rsp_timeout   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_ready     <= ready_d;
         m_apb_paddr   <= paddr_d;
         m_apb_psel    <= psel_d;
         m_apb_penable <= penable_d;
         m_apb_pwrite  <= pwrite_d;
         m_apb_pwdata  <= pwdata_d;
         m_apb_pstrb   <= pstrb_d;
         rsp_valid     <= rsp_valid_d;
         rsp_rdata     <= rsp_rdata_d;
         rsp_err       <= rsp_err_d;
         rsp_timeout   <= rsp_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ready_d       = cmd_ready;
      paddr_d       = m_apb_paddr;
      psel_d        = m_apb_psel;
      penable_d     = m_apb_penable;
      pwrite_d      = m_apb_pwrite;
      pwdata_d      = m_apb_pwdata;
      pstrb_d       = m_apb_pstrb;
      rsp_valid_d   = rsp_valid;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;
      // Saturating increment so the wait counter can never wrap.
      cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d   = SETUP;
               ready_d   = 1'b0;
               cnt_d     = '0;
               paddr_d   = cmd_addr;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_wdata;
               pstrb_d   = cmd_write ? cmd_strb : '0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end else begin
               ready_d = 1'b1;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            // Completion is checked first so a late pready beats the timeout.
            if (m_apb_pready) begin
               state_d       = RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = m_apb_pwrite ? '0 : m_apb_prdata;
               rsp_err_d     = m_apb_pslverr;
               rsp_timeout_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
               if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL)) begin
                  state_d       = RESP;
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = '0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               ready_d     = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboarded bench for apb_cmd_master against a configurable APB slave
// (wait states, error, hang) with TIMEOUT_CYCLES set to 4.
module tb_apb_cmd_master;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } rsp_t;

   logic        pclk;
   logic        prst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] m_apb_paddr;
   logic        m_apb_psel;
   logic        m_apb_penable;
   logic        m_apb_pwrite;
   logic [31:0] m_apb_pwdata;
   logic [3:0]  m_apb_pstrb;
   logic        m_apb_pready;
   logic [31:0] m_apb_prdata;
   logic        m_apb_pslverr;

   int          sl_wait;
   logic        sl_err;
   logic        sl_hang;
   logic [31:0] sl_rdata;
   int          acc_cnt;

   rsp_t        exp_q[$];
   int          n_checks;
   int          n_pass;

   logic [31:0] obs_addr;
   logic        obs_write;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_strb;

   apb_cmd_master #(
      .APB_AW(32),
      .APB_DW(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .pclk(pclk),
      .prst_n(prst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr),
      .cmd_write(cmd_write),
      .cmd_wdata(cmd_wdata),
      .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .m_apb_paddr(m_apb_paddr),
      .m_apb_psel(m_apb_psel),
      .m_apb_penable(m_apb_penable),
      .m_apb_pwrite(m_apb_pwrite),
      .m_apb_pwdata(m_apb_pwdata),
      .m_apb_pstrb(m_apb_pstrb),
      .m_apb_pready(m_apb_pready),
      .m_apb_prdata(m_apb_prdata),
      .m_apb_pslverr(m_apb_pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Slave: raises pready after sl_wait ACCESS cycles unless hung.
   assign m_apb_pready  = m_apb_psel && m_apb_penable && !sl_hang && (acc_cnt == sl_wait);
   assign m_apb_prdata  = sl_rdata;
   assign m_apb_pslverr = sl_err;

   always @(posedge pclk or negedge prst_n) begin
      if (!prst_n) acc_cnt <= 0;
      else if (m_apb_psel && m_apb_penable && !m_apb_pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   task automatic send_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input rsp_t want, output bit acc, output int waited);
      cmd_addr  = addr;
      cmd_write = wr;
      cmd_wdata = wdata;
      cmd_strb  = strb;
      cmd_valid = 1'b1;
      acc       = 1'b0;
      waited    = 0;
      while (!acc && waited < 32) begin
         @(negedge pclk);
         if (cmd_ready) acc = 1'b1;
         else waited++;
         @(posedge pclk);
      end
      #1;
      cmd_valid = 1'b0;
      if (acc) exp_q.push_back(want);
   endtask

   // Called right after the accept edge; index i = i-th edge after acceptance.
   task automatic get_rsp(output bit ok, output int psel_at, output int pen_at, output int rsp_rise,
                          output int acc_cyc, output bit stable);
      bit seen;
      ok = 1'b0; psel_at = -1; pen_at = -1; rsp_rise = -1; acc_cyc = 0; stable = 1'b1; seen = 1'b0;
      for (int i = 1; i <= 64 && !ok; i++) begin
         @(negedge pclk);
         if (m_apb_psel) begin
            if (psel_at < 0) psel_at = i;
            if (!seen) begin
               obs_addr = m_apb_paddr; obs_write = m_apb_pwrite;
               obs_wdata = m_apb_pwdata; obs_strb = m_apb_pstrb; seen = 1'b1;
            end else if (m_apb_paddr !== obs_addr || m_apb_pwrite !== obs_write ||
                         m_apb_pwdata !== obs_wdata || m_apb_pstrb !== obs_strb) begin
               stable = 1'b0;
            end
            if (m_apb_penable) begin
               if (pen_at < 0) pen_at = i;
               acc_cyc++;
            end
         end
         if (rsp_valid) begin
            ok = 1'b1;
            rsp_rise = i - 1;
         end
      end
   endtask

   task automatic test_reset();
      prst_n = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
      n_checks++; if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b000) $display("FAIL reset_apb_ctrl: got %b want 000", {m_apb_psel, m_apb_penable, m_apb_pwrite}); else n_pass++;
      n_checks++; if ({m_apb_paddr, m_apb_pwdata, m_apb_pstrb} !== 68'h0) $display("FAIL reset_apb_data: got %h want 0", {m_apb_paddr, m_apb_pwdata, m_apb_pstrb}); else n_pass++;
      n_checks++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0) $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); else n_pass++;
      @(negedge pclk);
      prst_n = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b0) $display("FAIL release_ready_early: got %b want 0", cmd_ready); else n_pass++;
      @(posedge pclk);
      #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_write();
      bit acc, ok, stable;
      int waited, psel_at, pen_at, rsp_rise, acc_cyc;
      rsp_t want;
      sl_wait = 0; sl_err = 1'b0; sl_hang = 1'b0; sl_rdata = 32'hA5A5_5A5A;
      want = '{rdata: 32'h0, err: 1'b0, tmo: 1'b0};
      send_cmd(32'h100, 1'b1, 32'hDEADBEEF, 4'hF, want, acc, waited);
      n_checks++; if (!acc) $display("FAIL write_accept: got %b want 1", acc); else n_pass++;
      get_rsp(ok, psel_at, pen_at, rsp_rise, acc_cyc, stable);
      n_checks++; if (!ok) $display("FAIL write_rsp_seen: got %b want 1", ok); else n_pass++;
      n_checks++; if (psel_at !== 1) $display("FAIL write_psel_latency: got %0d want 1", psel_at); else n_pass++;
      n_checks++; if (pen_at !== 2) $display("FAIL write_penable_latency: got %0d want 2", pen_at); else n_pass++;
      n_checks++; if (rsp_rise !== 2) $display("FAIL write_rsp_latency: got %0d want 2", rsp_rise); else n_pass++;
      n_checks++; if (acc_cyc !== 1) $display("FAIL write_access_len: got %0d want 1", acc_cyc); else n_pass++;
      n_checks++; if ({obs_addr, obs_write, obs_wdata, obs_strb} !== {32'h100, 1'b1, 32'hDEADBEEF, 4'hF})
         $display("FAIL write_apb_req: got %h/%b/%h/%h want 100/1/deadbeef/f", obs_addr, obs_write, obs_wdata, obs_strb); else n_pass++;
      n_checks++; if (!stable) $display("FAIL write_req_stable: got %b want 1", stable); else n_pass++;
      if (ok && exp_q.size() > 0) begin
         want = exp_q.pop_front();
         n_checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {want.rdata, want.err, want.tmo})
            $display("FAIL write_rsp_fields: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, want.rdata, want.err, want.tmo); else n_pass++;
      end
      exp_q.delete();
      @(posedge pclk); #1;
   endtask

   task automatic test_read_wait();
      bit acc, ok, stable;
      int waited, psel_at, pen_at, rsp_rise, acc_cyc;
      rsp_t want;
      sl_wait = 3; sl_err = 1'b0; sl_hang = 1'b0; sl_rdata = 32'h12345678;
      want = '{rdata: 32'h12345678, err: 1'b0, tmo: 1'b0};
      send_cmd(32'h104, 1'b0, 32'hFFFF_FFFF, 4'hF, want, acc, waited);
      n_checks++; if (!acc) $display("FAIL read_accept: got %b want 1", acc); else n_pass++;
      get_rsp(ok, psel_at, pen_at, rsp_rise, acc_cyc, stable);
      n_checks++; if (!ok) $display("FAIL read_rsp_seen: got %b want 1", ok); else n_pass++;
      n_checks++; if (acc_cyc !== 4) $display("FAIL read_access_len: got %0d want 4", acc_cyc); else n_pass++;
      n_checks++; if (obs_strb !== 4'h0) $display("FAIL read_pstrb: got %h want 0", obs_strb); else n_pass++;
      n_checks++; if (!stable) $display("FAIL read_req_stable: got %b want 1", stable); else n_pass++;
      if (ok && exp_q.size() > 0) begin
         want = exp_q.pop_front();
         n_checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {want.rdata, want.err, want.tmo})
            $display("FAIL read_rsp_fields: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, want.rdata, want.err, want.tmo); else n_pass++;
      end
      exp_q.delete();
      @(posedge pclk); #1;
   endtask

   task automatic test_error();
      bit acc, ok, stable;
      int waited, psel_at, pen_at, rsp_rise, acc_cyc;
      rsp_t want;
      sl_wait = 1; sl_err = 1'b1; sl_hang = 1'b0; sl_rdata = 32'h0BAD_0BAD;
      want = '{rdata: 32'h0BAD_0BAD, err: 1'b1, tmo: 1'b0};
      send_cmd(32'h108, 1'b0, 32'h0, 4'h0, want, acc, waited);
      get_rsp(ok, psel_at, pen_at, rsp_rise, acc_cyc, stable);
      n_checks++; if (!(acc && ok)) $display("FAIL error_rsp_seen: got %b want 1", acc && ok); else n_pass++;
      if (ok && exp_q.size() > 0) begin
         want = exp_q.pop_front();
         n_checks++; if ({rsp_err, rsp_timeout} !== {want.err, want.tmo})
            $display("FAIL error_flags: got %b/%b want %b/%b", rsp_err, rsp_timeout, want.err, want.tmo); else n_pass++;
         n_checks++; if (rsp_rdata !== want.rdata) $display("FAIL error_rdata: got %h want %h", rsp_rdata, want.rdata); else n_pass++;
      end
      exp_q.delete();
      @(posedge pclk); #1;
      sl_err = 1'b0;
   endtask

   task automatic test_timeout();
      bit acc, ok, stable;
      int waited, psel_at, pen_at, rsp_rise, acc_cyc;
      rsp_t want;
      sl_wait = 0; sl_err = 1'b0; sl_hang = 1'b1; sl_rdata = 32'hCAFE_F00D;
      want = '{rdata: 32'h0, err: 1'b1, tmo: 1'b1};
      send_cmd(32'h10C, 1'b0, 32'h0, 4'h0, want, acc, waited);
      get_rsp(ok, psel_at, pen_at, rsp_rise, acc_cyc, stable);
      n_checks++; if (!(acc && ok)) $display("FAIL timeout_rsp_seen: got %b want 1", acc && ok); else n_pass++;
      n_checks++; if (acc_cyc !== 4) $display("FAIL timeout_access_len: got %0d want 4", acc_cyc); else n_pass++;
      n_checks++; if (m_apb_psel !== 1'b0) $display("FAIL timeout_psel_drop: got %b want 0", m_apb_psel); else n_pass++;
      if (ok && exp_q.size() > 0) begin
         want = exp_q.pop_front();
         n_checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {want.rdata, want.err, want.tmo})
            $display("FAIL timeout_rsp_fields: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_err, rsp_timeout, want.rdata, want.err, want.tmo); else n_pass++;
      end
      exp_q.delete();
      @(posedge pclk); #1;
      sl_hang = 1'b0;
   endtask

   task automatic test_backpressure();
      bit acc, ok, stable;
      int waited, psel_at, pen_at, rsp_rise, acc_cyc;
      rsp_t want;
      sl_wait = 0; sl_err = 1'b0; sl_hang = 1'b0; sl_rdata = 32'h5555_AAAA;
      rsp_ready = 1'b0;
      want = '{rdata: 32'h5555_AAAA, err: 1'b0, tmo: 1'b0};
      send_cmd(32'h110, 1'b0, 32'h0, 4'h0, want, acc, waited);
      get_rsp(ok, psel_at, pen_at, rsp_rise, acc_cyc, stable);
      n_checks++; if (!(acc && ok)) $display("FAIL bp_rsp_seen: got %b want 1", acc && ok); else n_pass++;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         @(posedge pclk); @(negedge pclk);
         n_checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, want.rdata, want.err, want.tmo})
            $display("FAIL bp_hold_%0d: got %b/%h/%b/%b want 1/%h/%b/%b", i, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, want.rdata, want.err, want.tmo); else n_pass++;
         n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready_%0d: got %b want 0", i, cmd_ready); else n_pass++;
      end
      rsp_ready = 1'b1;
      @(posedge pclk); #1;
      n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL bp_release: got %b want 01", {rsp_valid, cmd_ready}); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_reset_mid_access();
      bit acc, seen, spur;
      int waited;
      rsp_t want;
      sl_wait = 0; sl_err = 1'b0; sl_hang = 1'b1; sl_rdata = 32'h0;
      want = '{rdata: 32'h0, err: 1'b0, tmo: 1'b0};
      send_cmd(32'h200, 1'b1, 32'h1111_2222, 4'h3, want, acc, waited);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge pclk);
         if (m_apb_penable) seen = 1'b1;
      end
      n_checks++; if (!(acc && seen)) $display("FAIL rst_reach_access: got %b want 1", acc && seen); else n_pass++;
      #2 prst_n = 1'b0;
      #1;
      n_checks++; if ({m_apb_psel, m_apb_penable} !== 2'b00) $display("FAIL rst_async_psel: got %b want 00", {m_apb_psel, m_apb_penable}); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
      exp_q.delete();
      @(posedge pclk); @(negedge pclk);
      prst_n = 1'b1; sl_hang = 1'b0;
      @(posedge pclk); #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready_after: got %b want 1", cmd_ready); else n_pass++;
      spur = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge pclk);
         if (rsp_valid || m_apb_psel) spur = 1'b1;
      end
      n_checks++; if (spur !== 1'b0) $display("FAIL rst_no_response: got %b want 0", spur); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit acc, ok, stable;
      int waited, psel_at, pen_at, rsp_rise, acc_cyc;
      rsp_t want;
      logic        wr;
      logic [31:0] addr, wdata;
      logic [3:0]  strb;
      @(posedge pclk); #1;
      for (int n = 0; n < 4; n++) begin
         wr = 1'(n % 2); addr = 32'h300 + 32'(n * 4); wdata = $urandom; strb = 4'($urandom_range(1, 15));
         sl_wait = $urandom_range(0, 2); sl_err = 1'($urandom_range(0, 1)); sl_hang = 1'b0; sl_rdata = $urandom;
         want = '{rdata: wr ? 32'h0 : sl_rdata, err: sl_err, tmo: 1'b0};
         send_cmd(addr, wr, wdata, strb, want, acc, waited);
         if (n > 0) begin
            n_checks++; if (waited !== 0) $display("FAIL b2b_accept_gap_%0d: got %0d want 0", n, waited); else n_pass++;
         end
         get_rsp(ok, psel_at, pen_at, rsp_rise, acc_cyc, stable);
         n_checks++; if (!(acc && ok)) $display("FAIL b2b_rsp_seen_%0d: got %b want 1", n, acc && ok); else n_pass++;
         n_checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_in_resp_%0d: got %b want 0", n, cmd_ready); else n_pass++;
         n_checks++; if ({obs_addr, obs_strb} !== {addr, wr ? strb : 4'h0})
            $display("FAIL b2b_apb_req_%0d: got %h/%h want %h/%h", n, obs_addr, obs_strb, addr, wr ? strb : 4'h0); else n_pass++;
         if (ok && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {want.rdata, want.err, want.tmo})
               $display("FAIL b2b_rsp_%0d: got %h/%b/%b want %h/%b/%b", n, rsp_rdata, rsp_err, rsp_timeout, want.rdata, want.err, want.tmo); else n_pass++;
         end
         exp_q.delete();
         @(posedge pclk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_pass = 0;
      prst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0;
      rsp_ready = 1'b1; sl_wait = 0; sl_err = 1'b0; sl_hang = 1'b0; sl_rdata = '0;
      test_reset();
      test_write();
      test_read_wait();
      test_error();
      test_timeout();
      test_backpressure();
      test_reset_mid_access();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
